// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: merges ALU and LSU writebacks onto one write port,
// with a halt sequence that drains outstanding writebacks before raising halted.
//   state    | meaning
//   S_RUN    | normal arbitration
//   S_DRAIN  | halt requested; still accepting until requesters and write port are idle
//   S_HALTED | no acceptances, halted=1, sticky until reset
module regfile_wb_arbiter #(
  parameter int XLEN       = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            lsu_valid,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  output logic            rd_we,
  output logic [4:0]      rd_num,
  output logic [XLEN-1:0] rd_data,
  input  logic            halt_req,
  output logic            halted,
  output logic [31:0]     wb_count
);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_last_lsu;
  logic            w_alu_gnt;
  logic            w_lsu_gnt;
  logic            w_accept;
  logic [4:0]      w_rd;
  logic [XLEN-1:0] w_data;
  logic            r_rd_we;
  logic [4:0]      r_rd_num;
  logic [XLEN-1:0] r_rd_data;
  logic [31:0]     r_wb_count;

  always_comb begin
    w_state_nxt = r_state;
    w_alu_gnt   = 1'b0;
    w_lsu_gnt   = 1'b0;
    if (r_state != S_HALTED) begin
      if (FIXED_PRIO != 0) begin
        w_lsu_gnt = lsu_valid;
        w_alu_gnt = alu_valid & ~lsu_valid;
      end else if (alu_valid && lsu_valid) begin
        // contested: the side that did not win last time gets it
        w_alu_gnt = r_last_lsu;
        w_lsu_gnt = ~r_last_lsu;
      end else begin
        w_alu_gnt = alu_valid;
        w_lsu_gnt = lsu_valid;
      end
    end
    case (r_state)
      S_RUN:   if (halt_req) w_state_nxt = S_DRAIN;
      S_DRAIN: if (!alu_valid && !lsu_valid && !r_rd_we) w_state_nxt = S_HALTED;
      default: w_state_nxt = r_state;
    endcase
  end

  assign w_accept = w_alu_gnt | w_lsu_gnt;
  assign w_rd     = w_lsu_gnt ? lsu_rd : alu_rd;
  assign w_data   = w_lsu_gnt ? lsu_data : alu_data;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state    <= S_RUN;
      r_last_lsu <= 1'b1;
      r_rd_we    <= 1'b0;
      r_rd_num   <= 5'd0;
      r_rd_data  <= '0;
      r_wb_count <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_rd_we <= w_accept && (w_rd != 5'd0);
      if (w_accept) begin
        r_last_lsu <= w_lsu_gnt;
        r_rd_num   <= w_rd;
        r_rd_data  <= w_data;
      end
      if (r_rd_we) r_wb_count <= r_wb_count + 32'd1;
    end
  end

  assign alu_ready = w_alu_gnt;
  assign lsu_ready = w_lsu_gnt;
  assign rd_we     = r_rd_we;
  assign rd_num    = r_rd_num;
  assign rd_data   = r_rd_data;
  assign halted    = (r_state == S_HALTED);
  assign wb_count  = r_wb_count;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench: round-robin (index 0) and fixed-priority (index 1) instances share stimulus;
// a reference model predicts grants and the write-port stream, a monitor checks the stream.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        alu_valid, lsu_valid, halt_req;
  logic [4:0]  alu_rd, lsu_rd;
  logic [31:0] alu_data, lsu_data;

  logic        alu_rdy [2];
  logic        lsu_rdy [2];
  logic        we      [2];
  logic [4:0]  num     [2];
  logic [31:0] dat     [2];
  logic        hlt     [2];
  logic [31:0] cnt     [2];

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.XLEN(32), .FIXED_PRIO(0)) dut_rr (
    .clk(clk), .rst_b(rst_b),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_rdy[0]),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_rdy[0]),
    .rd_we(we[0]), .rd_num(num[0]), .rd_data(dat[0]),
    .halt_req(halt_req), .halted(hlt[0]), .wb_count(cnt[0])
  );

  regfile_wb_arbiter #(.XLEN(32), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst_b(rst_b),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_rdy[1]),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_rdy[1]),
    .rd_we(we[1]), .rd_num(num[1]), .rd_data(dat[1]),
    .halt_req(halt_req), .halted(hlt[1]), .wb_count(cnt[1])
  );

  typedef struct {
    bit        we;
    bit [4:0]  num;
    bit [31:0] data;
    bit        halted;
    bit [31:0] cnt;
  } exp_t;

  exp_t q_rr[$];
  exp_t q_fp[$];

  // reference model: phase 0 running, 1 draining, 2 halted
  int        m_phase   [2];
  bit        m_last_lsu[2];
  bit        m_pending [2];
  bit [31:0] m_writes  [2];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_phase[m]    = 0;
      m_last_lsu[m] = 1'b1;
      m_pending[m]  = 1'b0;
      m_writes[m]   = 32'd0;
    end
    q_rr.delete();
    q_fp.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_b = 1'b0;
    alu_valid = 1'b0; lsu_valid = 1'b0; halt_req = 1'b0;
    model_reset();
    #1;
    for (int m = 0; m < 2; m++) begin
      check($sformatf("reset_rd_we[%0d]", m), 32'(we[m]), 32'd0);
      check($sformatf("reset_halted[%0d]", m), 32'(hlt[m]), 32'd0);
      check($sformatf("reset_wb_count[%0d]", m), cnt[m], 32'd0);
      check($sformatf("reset_rd_num[%0d]", m), 32'(num[m]), 32'd0);
    end
    @(posedge clk);
    #2 rst_b = 1'b1;
  endtask

  task automatic cycle(input bit av, input bit [4:0] ar, input bit [31:0] ad,
                       input bit lv, input bit [4:0] lr, input bit [31:0] ld, input bit hr);
    exp_t e;
    bit ga, gl;
    int nphase;
    @(negedge clk);
    alu_valid = av; alu_rd = ar; alu_data = ad;
    lsu_valid = lv; lsu_rd = lr; lsu_data = ld;
    halt_req  = hr;
    #1;
    for (int m = 0; m < 2; m++) begin
      ga = 1'b0; gl = 1'b0;
      if (m_phase[m] != 2) begin
        if (av && lv) begin
          if (m == 1) gl = 1'b1;
          else begin
            ga = m_last_lsu[m];
            gl = !m_last_lsu[m];
          end
        end else begin
          ga = av;
          gl = lv;
        end
      end
      check($sformatf("alu_ready[%0d]", m), 32'(alu_rdy[m]), 32'(ga));
      check($sformatf("lsu_ready[%0d]", m), 32'(lsu_rdy[m]), 32'(gl));
      if (ga || gl) m_last_lsu[m] = gl;
      e.cnt       = m_writes[m] + 32'(m_pending[m]);
      m_writes[m] = e.cnt;
      e.we   = (ga && ar != 5'd0) || (gl && lr != 5'd0);
      e.num  = gl ? lr : ar;
      e.data = gl ? ld : ad;
      nphase = m_phase[m];
      if (m_phase[m] == 0 && hr) nphase = 1;
      else if (m_phase[m] == 1 && !av && !lv && !m_pending[m]) nphase = 2;
      e.halted     = (nphase == 2);
      m_phase[m]   = nphase;
      m_pending[m] = e.we;
      if (m == 0) q_rr.push_back(e);
      else q_fp.push_back(e);
    end
  endtask

  task automatic idle(input int n, input bit hr);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, hr);
  endtask

  // monitor: compares the registered write port against the scoreboard after each edge
  initial begin
    exp_t e;
    bit got;
    forever begin
      @(posedge clk);
      #1;
      for (int m = 0; m < 2; m++) begin
        got = 1'b0;
        if (m == 0 && q_rr.size() > 0) begin e = q_rr.pop_front(); got = 1'b1; end
        if (m == 1 && q_fp.size() > 0) begin e = q_fp.pop_front(); got = 1'b1; end
        if (got) begin
          check($sformatf("rd_we[%0d]", m), 32'(we[m]), 32'(e.we));
          if (e.we) begin
            check($sformatf("rd_num[%0d]", m), 32'(num[m]), 32'(e.num));
            check($sformatf("rd_data[%0d]", m), dat[m], e.data);
          end
          check($sformatf("halted[%0d]", m), 32'(hlt[m]), 32'(e.halted));
          check($sformatf("wb_count[%0d]", m), cnt[m], e.cnt);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hr;
    rst_b = 1'b0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0; halt_req = 0;
    do_reset();

    cycle(1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
    idle(2, 0);

    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, 1, 32'h100 + i, 1, 2, 32'h200 + i, 0);
    cycle(1, 1, 32'h1FF, 0, 0, 0, 0);
    idle(2, 0);

    cycle(0, 0, 0, 1, 0, 32'h1234, 0);
    idle(1, 0);
    cycle(1, 7, 32'hAAAA0001, 1, 7, 32'h55550002, 0);
    cycle(1, 7, 32'hAAAA0001, 1, 7, 32'h55550002, 0);
    idle(2, 0);

    do_reset();
    cycle(1, 3, 32'h33, 0, 0, 0, 1);
    cycle(1, 4, 32'h44, 0, 0, 0, 1);
    idle(3, 1);
    cycle(1, 6, 32'h66, 1, 9, 32'h99, 0);
    idle(2, 0);

    do_reset();
    cycle(1, 8, 32'h88, 0, 0, 0, 0);
    idle(2, 0);

    for (int blk = 0; blk < 4; blk++) begin
      do_reset();
      hr = 1'b0;
      for (int i = 0; i < 300; i++) begin
        if (i > 100 && $urandom_range(0, 59) == 0) hr = 1'b1;
        if (blk == 3 && hr && $urandom_range(0, 9) == 0) break;
        cycle(hr ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0),
              5'($urandom_range(0, 31)), $urandom(),
              hr ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0),
              5'($urandom_range(0, 31)), $urandom(),
              hr | ($urandom_range(0, 3) == 0 && hr));
      end
    end
    idle(2, 0);
    @(posedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of writeback payloads and of rd_data.
REQ-002 SHALL have parameter FIXED_PRIO, default 0; 0 selects round-robin, 1 selects LSU fixed priority over ALU.
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_b  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports alu_valid  input  1, alu_rd  input  5, alu_data  input  XLEN: ALU writeback request.
REQ-006 SHALL have port alu_ready  output  1  ALU request accepted this cycle.
REQ-007 SHALL have ports lsu_valid  input  1, lsu_rd  input  5, lsu_data  input  XLEN: load-unit writeback request.
REQ-008 SHALL have port lsu_ready  output  1  LSU request accepted this cycle.
REQ-009 SHALL have ports rd_we  output  1, rd_num  output  5, rd_data  output  XLEN: register-file write port drive.
REQ-010 SHALL have port halt_req  input  1  level request to stop accepting writebacks.
REQ-011 SHALL have port halted  output  1  drain complete; drives the register-file halted input (dump trigger).
REQ-012 SHALL have port wb_count  output  32  number of committed register-file writes.

Function
REQ-013 SHALL accept a request on a cycle where valid and ready are both 1; ready SHALL be combinational from valid, state and arbitration pointer.
REQ-014 SHALL assert at most one of alu_ready/lsu_ready per cycle.
REQ-015 SHALL register the accepted request: rd_we/rd_num/rd_data reflect it exactly one cycle after acceptance, for exactly one cycle.
REQ-016 SHALL deassert rd_we on any cycle following no acceptance; rd_num/rd_data hold last value.
REQ-017 SHALL accept requests with rd=0 (ready asserted) but SHALL NOT assert rd_we nor increment wb_count for them.
REQ-018 Round-robin (FIXED_PRIO=0): single valid requester always granted; both valid -> grant requester not granted at last two-way-contested or single grant; pointer updates on every acceptance.
REQ-019 Fixed priority (FIXED_PRIO=1): both valid -> LSU granted; ALU granted only when lsu_valid=0.
REQ-020 SHALL implement state machine RUN, DRAIN, HALTED.
REQ-021 RUN: arbitrate per REQ-018/019; halt_req=1 -> DRAIN next cycle (grant in the same cycle still proceeds).
REQ-022 DRAIN: continue accepting valid requests (outstanding writebacks must retire); when alu_valid=0, lsu_valid=0 and rd_we=0 in the same cycle -> HALTED next cycle.
REQ-023 HALTED: alu_ready=lsu_ready=0, rd_we=0, halted=1; sticky until reset; halt_req deassertion ignored.
REQ-024 halted SHALL be 1 only in HALTED, registered (no combinational path from halt_req).
REQ-025 wb_count SHALL increment by 1 on each cycle rd_we=1, wrapping modulo 2^32.
REQ-026 Both requesters targeting the same rd in one cycle: loser stalls; writes commit in grant order, last write wins in the register file.
REQ-027 valid held high without ready SHALL keep payload stable (requester obligation); block SHALL not latch unaccepted payloads.

Reset
REQ-028 rst_b=0 SHALL asynchronously force: state RUN, rd_we=0, rd_num=0, rd_data=0, halted=0, wb_count=0, round-robin pointer = LSU-last (ALU wins first contest).
REQ-029 Reset mid-DRAIN or in HALTED SHALL return to RUN; writes accepted but not yet driven SHALL be discarded.
REQ-030 First acceptance SHALL be possible on the first rising edge after rst_b deasserts.

Verification
REQ-031 Single ALU write: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF -> alu_ready=1 same cycle; next cycle rd_we=1, rd_num=5, rd_data=0xDEADBEEF; wb_count=1 after.
REQ-032 Contention, FIXED_PRIO=0: both valid for 4 cycles (rd 1 vs 2) -> grants ALU,LSU,ALU,LSU; rd_num sequence 1,2,1,2 one cycle later.
REQ-033 Contention, FIXED_PRIO=1: both valid 3 cycles -> lsu_ready=1 all 3, alu_ready=0; ALU granted first cycle lsu_valid drops.
REQ-034 x0 write: lsu_valid=1, lsu_rd=0, data 0x1234 -> lsu_ready=1, rd_we stays 0, wb_count unchanged.
REQ-035 Halt drain: halt_req=1 with ALU valid 2 more cycles -> both accepted and written; halted=1 two cycles after last acceptance; later requests get ready=0.
REQ-036 Reset in HALTED: rst_b pulse low -> halted=0, wb_count=0, rd_we=0 immediately; ALU request accepted on first edge after release.
